// File: rtl/panxi_if_id.sv
// panxi_if_id: IF/ID boundary of the PANXI RV32 core.
// Two-entry elastic buffer between fetch and decode.
module panxi_if_id #(
  parameter int DW = 32,
  parameter int IW = 32,
  parameter logic [IW-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_valid_i,
  output logic          if_ready_o,
  input  logic [DW-1:0] if_inst_addr_i,
  input  logic [IW-1:0] if_inst_i,
  input  logic          if_fault_i,
  input  logic          stall_i,
  input  logic          flush_i,
  output logic          id_valid_o,
  input  logic          id_ready_i,
  output logic [DW-1:0] id_inst_addr_o,
  output logic [IW-1:0] id_inst_o,
  output logic          id_fault_o,
  output logic [1:0]    occupancy_o
);

  typedef struct packed {
    logic [DW-1:0] addr;
    logic [IW-1:0] inst;
    logic          fault;
  } ent_t;

  ent_t       mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  // Handshake terms; ready depends on registered state and reset only.
  always_comb begin
    if_ready_o = ~rst & (count != 2'd2);
    id_valid_o = (count != 2'd0);
    push = if_valid_i & if_ready_o & ~flush_i;
    pop  = id_valid_o & id_ready_i
         & ~stall_i & ~flush_i;
  end

  // Pointer and occupancy update; reset beats flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (flush_i) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= ~wr_ptr;
      if (pop)
        rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{
        addr:  if_inst_addr_i,
        inst:  if_inst_i,
        fault: if_fault_i
      };
  end

  // Head entry toward decode, NOP bubble when empty.
  always_comb begin
    id_inst_addr_o = '0;
    id_inst_o      = NOP_INST;
    id_fault_o     = 1'b0;
    occupancy_o    = count;
    if (id_valid_o) begin
      id_inst_addr_o = mem[rd_ptr].addr;
      id_inst_o      = mem[rd_ptr].inst;
      id_fault_o     = mem[rd_ptr].fault;
    end
  end

endmodule

// File: tb/tb_panxi_if_id.sv
// tb_panxi_if_id: randomized bench for panxi_if_id
// against a queue-based reference model.
module tb_panxi_if_id;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] i;
    logic        f;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid_i = 1'b0;
  logic        if_ready_o;
  logic [31:0] if_inst_addr_i = '0;
  logic [31:0] if_inst_i = '0;
  logic        if_fault_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_inst_addr_o;
  logic [31:0] id_inst_o;
  logic        id_fault_o;
  logic [1:0]  occupancy_o;

  int   n_chk = 0;
  int   n_err = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  panxi_if_id dut (
    .clk            (clk),
    .rst            (rst),
    .if_valid_i     (if_valid_i),
    .if_ready_o     (if_ready_o),
    .if_inst_addr_i (if_inst_addr_i),
    .if_inst_i      (if_inst_i),
    .if_fault_i     (if_fault_i),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .id_valid_o     (id_valid_o),
    .id_ready_i     (id_ready_i),
    .id_inst_addr_o (id_inst_addr_o),
    .id_inst_o      (id_inst_o),
    .id_fault_o     (id_fault_o),
    .occupancy_o    (occupancy_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, check before the edge,
  // advance the model at the edge.
  task automatic cyc(input logic r,
                     input logic v,
                     input logic [31:0] a,
                     input logic [31:0] i,
                     input logic f,
                     input logic rd,
                     input logic st,
                     input logic fl);
    ent_t e;
    bit   em;
    bit   do_push;
    bit   do_pop;
    rst = r;
    if_valid_i = v;
    if_inst_addr_i = a;
    if_inst_i = i;
    if_fault_i = f;
    id_ready_i = rd;
    stall_i = st;
    flush_i = fl;
    #1;
    em = (q.size() == 0);
    e = em ? '{a: 32'h0, i: NOP, f: 1'b0} : q[0];
    chk("id_valid", {31'h0, id_valid_o}, {31'h0, !em});
    chk("id_addr", id_inst_addr_o, e.a);
    chk("id_inst", id_inst_o, e.i);
    chk("id_fault", {31'h0, id_fault_o}, {31'h0, e.f});
    chk("occupancy", {30'h0, occupancy_o}, q.size());
    chk("if_ready", {31'h0, if_ready_o},
        {31'h0, !r && q.size() < 2});
    chk("ready_full",
        {31'h0, if_ready_o && occupancy_o == 2'd2}, 32'h0);
    do_push = !r && !fl && v && q.size() < 2;
    do_pop = !r && !fl && rd && !st && !em;
    @(posedge clk);
    if (r || fl) begin
      q.delete();
    end else begin
      if (do_pop)
        void'(q.pop_front());
      if (do_push)
        q.push_back('{a: a, i: i, f: f});
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rd);
    cyc(0, 0, 32'h0, 32'h0, 0, rd, 0, 0);
  endtask

  initial begin
    // first edge establishes a known state; no checks yet
    @(posedge clk);
    @(negedge clk);

    // reset then a single beat
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_inst", id_inst_o, NOP);
    chk("rst_ready", {31'h0, if_ready_o}, 32'h0);
    cyc(0, 1, 32'h0, 32'h0000_0093, 0, 1, 0, 0);
    chk("beat_valid", {31'h0, id_valid_o}, 32'h1);
    chk("beat_inst", id_inst_o, 32'h0000_0093);
    idle(1);
    chk("beat_nop", id_inst_o, NOP);
    chk("beat_occ", {30'h0, occupancy_o}, 32'h0);

    // stall fills the buffer
    cyc(0, 1, 32'h100, 32'hA100, 0, 1, 1, 0);
    cyc(0, 1, 32'h104, 32'hA104, 0, 1, 1, 0);
    cyc(0, 1, 32'h108, 32'hA108, 0, 1, 1, 0);
    chk("stall_occ", {30'h0, occupancy_o}, 32'h2);
    chk("stall_rdy", {31'h0, if_ready_o}, 32'h0);
    chk("stall_head", id_inst_addr_o, 32'h100);
    idle(1);
    chk("drain_1", id_inst_addr_o, 32'h104);
    idle(1);
    chk("drain_2", {31'h0, id_valid_o}, 32'h0);

    // steady stream
    for (int k = 0; k < 8; k++) begin
      cyc(0, 1, 32'h200 + 4 * k, 32'hB000 + k, 0, 1, 0, 0);
      chk("stream_occ", {30'h0, occupancy_o}, 32'h1);
      chk("stream_addr", id_inst_addr_o, 32'h200 + 4 * k);
    end
    idle(1);

    // flush while full with an incoming beat
    cyc(0, 1, 32'h300, 32'hC300, 0, 0, 0, 0);
    cyc(0, 1, 32'h304, 32'hC304, 0, 0, 0, 0);
    cyc(0, 1, 32'h308, 32'hC308, 0, 1, 0, 1);
    chk("flush_occ", {30'h0, occupancy_o}, 32'h0);
    chk("flush_valid", {31'h0, id_valid_o}, 32'h0);
    chk("flush_inst", id_inst_o, NOP);
    idle(1);

    // fault propagation
    cyc(0, 1, 32'h400, 32'hDEAD_BEEF, 1, 0, 0, 0);
    chk("fault_on", {31'h0, id_fault_o}, 32'h1);
    chk("fault_addr", id_inst_addr_o, 32'h400);
    cyc(0, 1, 32'h404, 32'h0000_0093, 0, 1, 0, 0);
    chk("fault_off", {31'h0, id_fault_o}, 32'h0);
    idle(1);

    // random backpressure, with rare flush and one reset
    for (int k = 0; k < 1000; k++) begin
      cyc(k == 500,
          1'($urandom_range(0, 1)),
          32'h1000 + 4 * k,
          $urandom,
          1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 63) == 0));
    end
    for (int k = 0; k < 4; k++)
      idle(1);
    chk("end_empty", {30'h0, occupancy_o}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
